// File: rtl/pc_gen.sv
// IF-stage fetch-address generator: holds the PC, runs the request/grant fetch
// handshake and applies branch redirects, exception flushes and alignment checks.
module pc_gen #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = '0,
  parameter int unsigned          INST_BYTES = 4,
  parameter int unsigned          STALL_W    = 6,
  parameter bit                   ALIGN_CHK  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               inst_gnt,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               inst_req,
  output logic               adel_o,
  output logic [1:0]         state,
  output logic               pend_vld
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);

  state_t            cur_state, nxt_state;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
  logic              acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      pc_q      <= RESET_VEC;
      pend_addr <= '0;
    end else begin
      cur_state <= nxt_state;
      pc_q      <= pc_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  // Priority: flush > accept-with-pending > accept-with-branch > accept > buffer branch.
  always_comb begin
    nxt_state     = cur_state;
    pc_nxt        = pc_q;
    pend_addr_nxt = pend_addr;
    case (cur_state)
      IDLE: nxt_state = RUN;
      default: begin
        if (flush) begin
          pc_nxt    = new_pc;
          nxt_state = RUN;
        end else if (acc && cur_state == PEND) begin
          pc_nxt = pend_addr;
          if (branch_flag) begin
            pend_addr_nxt = branch_addr;
            nxt_state     = PEND;
          end else begin
            nxt_state = RUN;
          end
        end else if (acc && branch_flag) begin
          pc_nxt = branch_addr;
        end else if (acc) begin
          pc_nxt = pc_q + STEP;
        end else if (branch_flag) begin
          pend_addr_nxt = branch_addr;
          nxt_state     = PEND;
        end
      end
    endcase
  end

  always_comb begin
    ce       = (cur_state != IDLE);
    adel_o   = ALIGN_CHK && ce && ((pc_q & ALIGN_MASK) != '0);
    inst_req = ce && !stall[0] && !flush && !adel_o;
    acc      = inst_req && inst_gnt;
    pc       = pc_q;
    state    = cur_state;
    pend_vld = (cur_state == PEND);
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: inputs driven and outputs checked on the falling edge.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [1:0]  S_IDLE = 2'd0, S_RUN = 2'd1, S_PEND = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        inst_gnt;
  logic [31:0] pc;
  logic        ce, inst_req, adel_o, pend_vld;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  pc_gen #(.ADDR_W(32), .RESET_VEC(RV), .INST_BYTES(4), .STALL_W(6), .ALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_addr(branch_addr), .inst_gnt(inst_gnt),
    .pc(pc), .ce(ce), .inst_req(inst_req), .adel_o(adel_o),
    .state(state), .pend_vld(pend_vld)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = '0; flush = 0; new_pc = '0; branch_flag = 0; branch_addr = '0; inst_gnt = 0;
  endtask

  task automatic do_flush(input logic [31:0] addr);
    flush = 1; new_pc = addr;
    tick();
    flush = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    check("rst_pc", pc, RV);
    check("rst_ce", 32'(ce), 0);
    check("rst_req", 32'(inst_req), 0);
    check("rst_adel", 32'(adel_o), 0);
    check("rst_state", 32'(state), 32'(S_IDLE));

    // 1: first fetch from reset vector, sequential increments
    @(negedge clk); rst = 0; inst_gnt = 1; #1;
    check("t1_ce_pre", 32'(ce), 0);
    tick();
    check("t1_ce", 32'(ce), 1);
    check("t1_pc0", pc, 32'hBFC0_0000);
    check("t1_req", 32'(inst_req), 1);
    tick(); check("t1_pc1", pc, 32'hBFC0_0004);
    tick(); check("t1_pc2", pc, 32'hBFC0_0008);

    // 2: grant withheld holds pc with request up
    inst_gnt = 0;
    do_flush(32'h100);
    check("t2_pc_flush", pc, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_pc_hold", pc, 32'h100);
      check("t2_req_hold", 32'(inst_req), 1);
    end
    inst_gnt = 1; tick(); inst_gnt = 0;
    check("t2_pc_inc", pc, 32'h104);

    // stall[0] blocks acceptance; upper stall bits are ignored
    inst_gnt = 1; stall = 6'b000001; #1;
    check("st_req", 32'(inst_req), 0);
    tick(); check("st_pc_hold", pc, 32'h104);
    stall = 6'b111110; tick();
    check("st_hi_ignored", pc, 32'h108);
    stall = '0; inst_gnt = 0;

    // 3: branch buffered while grant low
    do_flush(32'h20);
    branch_flag = 1; branch_addr = 32'h400; tick(); branch_flag = 0;
    check("t3_state", 32'(state), 32'(S_PEND));
    check("t3_pc_hold", pc, 32'h20);
    inst_gnt = 1; tick(); inst_gnt = 0;
    check("t3_pc_redir", pc, 32'h400);
    check("t3_state_run", 32'(state), 32'(S_RUN));
    do_flush(32'h20);
    branch_flag = 1; branch_addr = 32'h400; tick();
    branch_addr = 32'h500; tick(); branch_flag = 0;
    check("t3_pend2", 32'(pend_vld), 1);
    inst_gnt = 1; tick(); inst_gnt = 0;
    check("t3_pc_newest", pc, 32'h500);

    // accept in PEND with a fresh branch: pending target taken, new one buffered
    branch_flag = 1; branch_addr = 32'h600; tick();
    branch_addr = 32'h640; inst_gnt = 1; tick(); branch_flag = 0; inst_gnt = 0;
    check("pp_pc", pc, 32'h600);
    check("pp_state", 32'(state), 32'(S_PEND));
    inst_gnt = 1; tick(); inst_gnt = 0;
    check("pp_pc2", pc, 32'h640);

    // 4: flush beats branch, stall and pending buffer
    branch_flag = 1; branch_addr = 32'h600; tick();
    check("t4_pend", 32'(pend_vld), 1);
    flush = 1; new_pc = 32'h380; branch_addr = 32'h700; stall = 6'b000001; inst_gnt = 1; #1;
    check("t4_req_low", 32'(inst_req), 0);
    tick(); idle_inputs();
    check("t4_pc", pc, 32'h380);
    check("t4_pend_clr", 32'(pend_vld), 0);

    // 5: misaligned branch target
    branch_flag = 1; branch_addr = 32'h202; inst_gnt = 1; tick(); branch_flag = 0;
    for (int i = 0; i < 5; i++) begin
      check("t5_adel", 32'(adel_o), 1);
      check("t5_req", 32'(inst_req), 0);
      check("t5_pc", pc, 32'h202);
      tick();
    end
    do_flush(32'h380);
    check("t5_adel_clr", 32'(adel_o), 0);
    check("t5_pc_flush", pc, 32'h380);
    inst_gnt = 0;

    // 6: wrap at top of address space, then async reset mid-PEND
    do_flush(32'hFFFF_FFFC);
    check("t6_pc_top", pc, 32'hFFFF_FFFC);
    inst_gnt = 1; tick(); inst_gnt = 0;
    check("t6_wrap", pc, 32'h0);
    branch_flag = 1; branch_addr = 32'h400; tick(); branch_flag = 0;
    check("t6_pend", 32'(pend_vld), 1);
    rst = 1; #1;
    check("t6_rst_pc", pc, RV);
    check("t6_rst_ce", 32'(ce), 0);
    check("t6_rst_pend", 32'(pend_vld), 0);
    check("t6_rst_req", 32'(inst_req), 0);
    @(negedge clk); rst = 0; inst_gnt = 1;
    tick();
    check("t6_rerun_ce", 32'(ce), 1);
    check("t6_rerun_pc", pc, RV);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
